// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl
// Transaction sequencer between a host command/byte stream and a byte-level
// SPI master engine. A command selects one active-low chip select and a
// length of cmd_len_i+1 bytes. The block asserts the chip select and waits a
// setup time. It then hands bytes to the engine one at a time and forwards
// every received byte back to the host. After a hold time it releases the
// chip select, pulses done_o (with err_o on abort or a bad slave index), and
// keeps the chip selects high for an idle gap before taking the next command.
//
// Ports:
//   clk_i, reset_l_i          clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake (ready only while idle)
//   cmd_cs_i, cmd_len_i       slave index, byte count minus one
//   abort_i                   terminate the current transaction
//   tx_byte_i/tx_valid_i/tx_ready_o   host byte stream into the engine
//   rx_byte_o/rx_valid_o      received bytes, one-cycle pulse each
//   done_o/err_o/busy_o       completion pulse, error qualifier, activity
//   cs_n_o                    registered active-low chip selects
//   m_tx_data_byte_o/m_tx_data_valid_o/m_tx_ready_i   engine byte issue
//   m_rx_data_byte_i/m_rx_data_valid_i                engine byte done
module spi_xfer_ctrl #(
   parameter int NUM_CS       = 4,
   parameter int CS_IDX_W     = 2,
   parameter int LEN_W        = 8,
   parameter int CS_SETUP_CYC = 2,
   parameter int CS_HOLD_CYC  = 2,
   parameter int CS_IDLE_CYC  = 2
) (
   input  logic                clk_i,
   input  logic                reset_l_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [CS_IDX_W-1:0] cmd_cs_i,
   input  logic [LEN_W-1:0]    cmd_len_i,
   input  logic                abort_i,
   input  logic [7:0]          tx_byte_i,
   input  logic                tx_valid_i,
   output logic                tx_ready_o,
   output logic [7:0]          rx_byte_o,
   output logic                rx_valid_o,
   output logic                done_o,
   output logic                err_o,
   output logic                busy_o,
   output logic [NUM_CS-1:0]   cs_n_o,
   output logic [7:0]          m_tx_data_byte_o,
   output logic                m_tx_data_valid_o,
   input  logic                m_tx_ready_i,
   input  logic [7:0]          m_rx_data_byte_i,
   input  logic                m_rx_data_valid_i
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETUP   = 3'd1;
   localparam logic [2:0] ST_LOAD    = 3'd2;
   localparam logic [2:0] ST_WAIT_RX = 3'd3;
   localparam logic [2:0] ST_HOLD    = 3'd4;
   localparam logic [2:0] ST_GAP     = 3'd5;

   // One shared timer serves setup, hold and gap; it only has to reach the
   // largest terminal value of the three.
   localparam int TMR_MAXV = (CS_SETUP_CYC > CS_HOLD_CYC) ?
                             ((CS_SETUP_CYC > CS_IDLE_CYC) ? CS_SETUP_CYC : CS_IDLE_CYC) :
                             ((CS_HOLD_CYC > CS_IDLE_CYC) ? CS_HOLD_CYC : CS_IDLE_CYC);
   localparam int TMR_W = (TMR_MAXV < 2) ? 1 : $clog2(TMR_MAXV);

   localparam logic [TMR_W-1:0]  SETUP_LAST = TMR_W'(CS_SETUP_CYC - 1);
   localparam logic [TMR_W-1:0]  HOLD_LAST  = TMR_W'(CS_HOLD_CYC - 1);
   localparam logic [TMR_W-1:0]  IDLE_LAST  = TMR_W'(CS_IDLE_CYC - 1);
   localparam logic [CS_IDX_W:0] NUM_CS_L   = (CS_IDX_W + 1)'(NUM_CS);

   logic [2:0]          state_q, state_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic                abortPend_q, abortPend_d;
   logic [NUM_CS-1:0]   csN_q, csN_d;
   logic [7:0]          txByte_q, txByte_d;
   logic                txValid_q, txValid_d;
   logic [7:0]          rxByte_q, rxByte_d;
   logic                rxValid_q, rxValid_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   // Abort takes priority over a byte handshake in LOAD, so the host never
   // sees its byte accepted in a cycle where the transaction is being killed.
   assign tx_ready_o  = (state_q == ST_LOAD) && m_tx_ready_i && !abort_i;
   assign cmd_ready_o = (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);

   assign cs_n_o            = csN_q;
   assign m_tx_data_byte_o  = txByte_q;
   assign m_tx_data_valid_o = txValid_q;
   assign rx_byte_o         = rxByte_q;
   assign rx_valid_o        = rxValid_q;
   assign done_o            = done_q;
   assign err_o             = err_q;

   // Next-state logic. The pulse outputs (engine start, rx forward, done)
   // default to zero every cycle and are raised only on the cycle that
   // produces them. cnt_q holds the number of bytes still to transfer after
   // the current one. It is loaded with cmd_len_i directly, so the largest
   // length runs its full 2**LEN_W bytes without wrapping.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      cnt_d       = cnt_q;
      abortPend_d = abortPend_q;
      csN_d       = csN_q;
      txByte_d    = txByte_q;
      txValid_d   = 1'b0;
      rxByte_d    = rxByte_q;
      rxValid_d   = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               cnt_d       = cmd_len_i;
               abortPend_d = 1'b0;
               timer_d     = '0;
               if ({1'b0, cmd_cs_i} >= NUM_CS_L) begin
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  state_d = ST_GAP;
               end else begin
                  csN_d   = ~(NUM_CS'(1) << cmd_cs_i);
                  state_d = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            if (abort_i) begin
               abortPend_d = 1'b1;
               timer_d     = '0;
               state_d     = ST_HOLD;
            end else if (timer_q == SETUP_LAST) begin
               timer_d = '0;
               state_d = ST_LOAD;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_LOAD: begin
            if (abort_i) begin
               abortPend_d = 1'b1;
               timer_d     = '0;
               state_d     = ST_HOLD;
            end else if (tx_valid_i && m_tx_ready_i) begin
               txByte_d  = tx_byte_i;
               txValid_d = 1'b1;
               state_d   = ST_WAIT_RX;
            end
         end
         ST_WAIT_RX: begin
            if (abort_i) begin
               abortPend_d = 1'b1;
            end
            if (m_rx_data_valid_i) begin
               rxByte_d  = m_rx_data_byte_i;
               rxValid_d = 1'b1;
               if ((cnt_q == '0) || abortPend_q || abort_i) begin
                  timer_d = '0;
                  state_d = ST_HOLD;
               end else begin
                  cnt_d   = cnt_q - LEN_W'(1);
                  state_d = ST_LOAD;
               end
            end
         end
         ST_HOLD: begin
            if (timer_q == HOLD_LAST) begin
               csN_d   = '1;
               done_d  = 1'b1;
               err_d   = abortPend_q;
               timer_d = '0;
               state_d = ST_GAP;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_GAP: begin
            if (timer_q == IDLE_LAST) begin
               timer_d = '0;
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: begin
            csN_d   = '1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers. Reset drops any in-flight transfer immediately: the
   // chip selects go high without waiting for a clock, and no done pulse is
   // produced.
   always_ff @(posedge clk_i or negedge reset_l_i) begin
      if (!reset_l_i) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         cnt_q       <= '0;
         abortPend_q <= 1'b0;
         csN_q       <= '1;
         txByte_q    <= '0;
         txValid_q   <= 1'b0;
         rxByte_q    <= '0;
         rxValid_q   <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         cnt_q       <= cnt_d;
         abortPend_q <= abortPend_d;
         csN_q       <= csN_d;
         txByte_q    <= txByte_d;
         txValid_q   <= txValid_d;
         rxByte_q    <= rxByte_d;
         rxValid_q   <= rxValid_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transaction sequencer that sits between a host command/byte-stream interface and the byte-level SPI master engine. It accepts a command (target slave index, byte count), drives the selected active-low chip select, and issues bytes to the engine one at a time. It forwards each received byte back to the host and enforces CS setup, hold and inter-transaction idle timing. It then reports completion, or reports an error on abort or an invalid slave index.

Parameters:
NUM_CS, 4, number of chip-select outputs (1..2**CS_IDX_W)
CS_IDX_W, 2, width of slave index field
LEN_W, 8, width of length field; transfer = cmd_len_i+1 bytes
CS_SETUP_CYC, 2, clk_i cycles from CS assert to first byte issue (>=1)
CS_HOLD_CYC, 2, clk_i cycles from last rx byte to CS deassert (>=1)
CS_IDLE_CYC, 2, minimum clk_i cycles CS stays high before next command is accepted (>=1)

Ports:
clk_i  in  1  clock
reset_l_i  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accept (high only in IDLE)
cmd_cs_i  in  CS_IDX_W  target slave index
cmd_len_i  in  LEN_W  byte count minus one
abort_i  in  1  terminate current transaction
tx_byte_i  in  8  host byte to send
tx_valid_i  in  1  host byte valid
tx_ready_o  out  1  host byte accepted this cycle when tx_valid_i also high
rx_byte_o  out  8  received byte
rx_valid_o  out  1  one-cycle pulse per received byte (no backpressure)
done_o  out  1  one-cycle pulse at end of transaction
err_o  out  1  qualifies done_o: aborted or invalid index
busy_o  out  1  high whenever state != IDLE
cs_n_o  out  NUM_CS  active-low chip selects, registered
m_tx_data_byte_o  out  8  byte to SPI engine
m_tx_data_valid_o  out  1  one-cycle start pulse to SPI engine
m_tx_ready_i  in  1  SPI engine idle
m_rx_data_byte_i  in  8  byte from SPI engine
m_rx_data_valid_i  in  1  SPI engine byte-done pulse

Behaviour:
- Reset (async, any state): state IDLE. cs_n_o all 1. All other outputs 0 except cmd_ready_o=1. Counters 0. Any in-flight transfer is dropped without a done_o pulse.
- States: IDLE, SETUP, LOAD, WAIT_RX, HOLD, GAP.
- IDLE:
  - cmd_valid_i & cmd_ready_o at edge T latches cs index and len.
  - If index >= NUM_CS: done_o=1, err_o=1 at T+1. CS stays high. Next state is GAP.
  - Otherwise: the selected cs_n_o bit goes low at T+1. Next state is SETUP.
- SETUP: counts CS_SETUP_CYC cycles, then goes to LOAD. The first byte can therefore be accepted no earlier than T+1+CS_SETUP_CYC.
- LOAD:
  - tx_ready_o = m_tx_ready_i (combinational); it is 0 in every other state.
  - On tx_valid_i & m_tx_ready_i: m_tx_data_byte_o <= tx_byte_i and m_tx_data_valid_o <= 1 for exactly one cycle. Next state is WAIT_RX.
- WAIT_RX:
  - Ignores m_tx_ready_i.
  - On m_rx_data_valid_i: rx_byte_o <= m_rx_data_byte_i and rx_valid_o pulses in the next cycle.
  - If the remaining count is 0, or an abort is pending: go to HOLD. Otherwise decrement the count and go to LOAD.
- HOLD: CS stays low for CS_HOLD_CYC cycles. The cycle CS goes high, done_o pulses, with err_o=1 if the transaction was aborted. Next state is GAP.
- GAP: CS stays high for CS_IDLE_CYC cycles, then the state returns to IDLE.
- abort_i:
  - In SETUP or LOAD: go to HOLD next cycle; no further bytes are issued.
  - In WAIT_RX: sets a pending flag; the current byte completes and is forwarded, then the state goes to HOLD.
  - Ignored in IDLE, HOLD and GAP.
  - In LOAD, if abort_i and a byte handshake occur in the same cycle, abort wins: no byte is issued and tx_ready_o is forced to 0.
- Length wrap: cmd_len_i = 2**LEN_W-1 transfers 2**LEN_W bytes. The counter must not wrap early.
- Exactly one cs_n_o bit is low at any time, or none.
- An m_rx_data_valid_i pulse outside WAIT_RX is ignored and not forwarded.

Test Plan:
- Reset, then cmd cs=1 len=2, host bytes A5,3C,F0, engine echoes inverted. Required: cs_n_o=4'b1101 for the whole transfer, three m_tx_data_valid_o pulses in order, rx_byte_o 5A,C3,0F, then one done_o with err_o=0, and cs_n_o returns to 4'b1111.
- Timing: with CS_SETUP_CYC=2, the first tx_ready_o is no earlier than 3 cycles after command accept. CS stays low 2 cycles after the last rx_valid_o. cmd_ready_o stays low for 2 cycles after CS rises.
- NUM_CS=3, cmd cs=3. Required: done_o+err_o 1 cycle after accept, no cs_n_o activity, no m_tx_data_valid_o.
- Abort in WAIT_RX of byte 1 of a 4-byte transfer. Required: byte 1 forwarded, no byte 2 issued, done_o with err_o=1 after HOLD. Abort asserted in the same cycle as a LOAD handshake: no byte is issued.
- len=255, 256 bytes with incrementing data. Required: exactly 256 rx_valid_o pulses and a single done_o.
- reset_l_i low mid-WAIT_RX. Required: cs_n_o all 1 immediately (asynchronous), no done_o, and a new command after reset completes normally.
